// File: rtl/next_block_queue_if.sv
// Shared piece type and the spawn/preview bus of the next-block queue.
//
// next_block_pkg
//   color_t      : 3-bit piece color, 1..7 are real colors, 0 means "none"
//   block_info_t : packed {kind, color} as produced by the generator
//
// next_block_queue_if (DEPTH = FIFO entries, sizes count_o)
//   spawn_req_i      game FSM ready to take the head piece
//   spawn_valid_o    head entry valid (FIFO non-empty)
//   spawn_block_o    head entry
//   preview_valid_o  at least two entries buffered
//   preview_block_o  entry behind the head
//   count_o          occupancy
//   modport master : the queue side, modport slave : the game FSM / renderer side
package next_block_pkg;
  typedef logic [2:0] color_t;

  typedef struct packed {
    logic [2:0] kind;
    color_t     color;
  } block_info_t;
endpackage

interface next_block_queue_if
  import next_block_pkg::*;
#(
  parameter int DEPTH = 3
);
  logic                       spawn_req_i;
  logic                       spawn_valid_o;
  block_info_t                spawn_block_o;
  logic                       preview_valid_o;
  block_info_t                preview_block_o;
  logic [$clog2(DEPTH+1)-1:0] count_o;

  modport master (
    input  spawn_req_i,
    output spawn_valid_o, spawn_block_o, preview_valid_o, preview_block_o, count_o
  );

  modport slave (
    output spawn_req_i,
    input  spawn_valid_o, spawn_block_o, preview_valid_o, preview_block_o, count_o
  );
endinterface

// File: rtl/next_block_queue.sv
// Consumer side of the random next-block generator. A fill FSM steps the
// generator, waits for its pipeline to settle, rejects immediate color repeats
// (bounded rerolls) and pushes accepted pieces into a small shift-register FIFO.
// Entry 0 is the piece to spawn, entry 1 the preview.
//
// Ports
//   clk_i        system clock
//   rst_n_i      asynchronous active-low reset
//   gen_en_o     one-cycle step pulse to the generator
//   gen_block_i  generator output
//   flush_i      synchronous clear (new game), overrides everything else
//   q_if         spawn handshake, preview and occupancy (master modport)
//
// Assumes GEN_LATENCY >= 2 and DEPTH >= 2.
module next_block_queue
  import next_block_pkg::*;
#(
  parameter int DEPTH       = 3,
  parameter int GEN_LATENCY = 3,
  parameter int MAX_REROLL  = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  output logic                      gen_en_o,
  input  block_info_t               gen_block_i,
  input  logic                      flush_i,
  next_block_queue_if.master        q_if
);

  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int WAIT_W = (GEN_LATENCY > 2) ? $clog2(GEN_LATENCY) : 1;
  localparam int RR_W   = (MAX_REROLL > 0) ? $clog2(MAX_REROLL + 1) : 1;

  typedef enum logic [1:0] {IDLE, STEP, WAIT, CHECK} state_e;

  state_e             state_q;
  logic               gen_en_q;
  logic [WAIT_W-1:0]  wait_cnt_q;
  logic [RR_W-1:0]    reroll_q;
  color_t             last_color_q;

  logic [CNT_W-1:0]   count_q, count_d;
  block_info_t        mem_q [DEPTH];
  block_info_t        mem_d [DEPTH];
  logic [CNT_W-1:0]   wr_idx;

  logic               repeat_hit;
  logic               push;
  logic               pop;

  // A repeat is only rejected while reroll budget remains; after that the
  // repeated color is accepted so the queue always makes progress.
  assign repeat_hit = (gen_block_i.color == last_color_q) &&
                      (reroll_q < RR_W'(MAX_REROLL));
  assign push       = (state_q == CHECK) && !repeat_hit && !flush_i;
  assign pop        = (count_q != '0) && q_if.spawn_req_i && !flush_i;

  // Fill FSM. CHECK is entered when the generator output is stable, so a
  // fresh STEP always precedes any sample; pushes never overflow because only
  // IDLE with free space starts a fill and pops can only free more space.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      gen_en_q     <= 1'b0;
      wait_cnt_q   <= '0;
      reroll_q     <= '0;
      last_color_q <= '0;
    end else if (flush_i) begin
      state_q      <= IDLE;
      gen_en_q     <= 1'b0;
      wait_cnt_q   <= '0;
      reroll_q     <= '0;
      last_color_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (count_q < CNT_W'(DEPTH)) begin
            state_q  <= STEP;
            gen_en_q <= 1'b1;
          end
        end
        STEP: begin
          gen_en_q   <= 1'b0;
          wait_cnt_q <= '0;
          state_q    <= WAIT;
        end
        WAIT: begin
          // Counter value after this increment reaching GEN_LATENCY-1 means
          // the generator output is stable in the next cycle.
          wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
          if (wait_cnt_q == WAIT_W'(GEN_LATENCY - 2)) state_q <= CHECK;
        end
        CHECK: begin
          if (repeat_hit) begin
            reroll_q <= reroll_q + RR_W'(1);
            state_q  <= STEP;
            gen_en_q <= 1'b1;
          end else begin
            last_color_q <= gen_block_i.color;
            reroll_q     <= '0;
            state_q      <= IDLE;
          end
        end
        default: begin
          state_q  <= IDLE;
          gen_en_q <= 1'b0;
        end
      endcase
    end
  end

  // FIFO next state: pop shifts toward the head first, then a push lands at
  // the tail slot computed from the post-pop occupancy.
  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    wr_idx  = count_q - CNT_W'(pop);
    if (flush_i) begin
      count_d = '0;
      mem_d   = '{default: '0};
    end else begin
      if (pop) begin
        for (int i = 0; i < DEPTH - 1; i++) mem_d[i] = mem_q[i+1];
        mem_d[DEPTH-1] = '0;
      end
      if (push) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (wr_idx == CNT_W'(i)) mem_d[i] = gen_block_i;
        end
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q <= '0;
      mem_q   <= '{default: '0};
    end else begin
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

  // Flush suppresses a step issued in the same cycle.
  assign gen_en_o             = gen_en_q & ~flush_i;
  assign q_if.spawn_valid_o   = (count_q != '0);
  assign q_if.preview_valid_o = (count_q >= CNT_W'(2));
  assign q_if.spawn_block_o   = mem_q[0];
  assign q_if.preview_block_o = mem_q[1];
  assign q_if.count_o         = count_q;

endmodule

// File: tb/tb_next_block_queue.sv
module tb_next_block_queue;
  import next_block_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        gen_en;
  block_info_t gen_block;
  logic        flush;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  next_block_queue_if #(.DEPTH(3)) q_if ();

  next_block_queue #(.DEPTH(3), .GEN_LATENCY(3), .MAX_REROLL(2)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .gen_en_o    (gen_en),
    .gen_block_i (gen_block),
    .flush_i     (flush),
    .q_if        (q_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Generator model: each step consumes the next scripted value (or a
  // rolling default) and presents it GEN_LATENCY=3 cycles after the pulse.
  block_info_t gen_q[$];
  block_info_t exp_q[$];
  int          pulse_cyc[$];
  block_info_t g1 = '0, g2 = '0;
  int          dflt_n = 0;

  initial gen_block = '0;

  always @(posedge clk) begin
    if (gen_en) begin
      pulse_cyc.push_back(cyc);
      if (gen_q.size() != 0) g1 <= gen_q.pop_front();
      else begin
        g1     <= '{kind: 3'd7, color: 3'(1 + (dflt_n % 7))};
        dflt_n <= dflt_n + 1;
      end
    end
    g2        <= g1;
    gen_block <= g2;
  end

  function automatic block_info_t mk(input int k, input int c);
    return '{kind: 3'(k), color: 3'(c)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_count(input int target, input int budget, input string tag);
    int n = 0;
    while (int'(q_if.count_o) != target && n < budget) begin
      tick(1);
      n++;
    end
    chk(tag, 32'(q_if.count_o), 32'(target));
  endtask

  task automatic wait_gen(input int budget, input string tag);
    int n = 0;
    while (gen_en !== 1'b1 && n < budget) begin
      tick(1);
      n++;
    end
    chk(tag, 32'(gen_en), 32'd1);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
  endtask

  // Head must match the scoreboard front; then pop it for one edge.
  task automatic pop_one(input string tag);
    block_info_t e;
    e = exp_q.pop_front();
    chk(tag, 32'(q_if.spawn_block_o), 32'(e));
    q_if.spawn_req_i = 1'b1;
    tick(1);
    q_if.spawn_req_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n            = 1'b0;
    flush            = 1'b0;
    q_if.spawn_req_i = 1'b0;

    // Reset state
    tick(3);
    chk("rst_gen_en",   32'(gen_en), 32'd0);
    chk("rst_count",    32'(q_if.count_o), 32'd0);
    chk("rst_spawn_v",  32'(q_if.spawn_valid_o), 32'd0);
    chk("rst_prev_v",   32'(q_if.preview_valid_o), 32'd0);
    chk("rst_spawn_b",  32'(q_if.spawn_block_o), 32'd0);

    // 1: initial fill 3,5,1 at one piece per 5 cycles
    gen_q = '{mk(1, 3), mk(2, 5), mk(3, 1)};
    exp_q = '{mk(1, 3), mk(2, 5), mk(3, 1)};
    pulse_cyc.delete();
    rst_n = 1'b1;
    wait_count(3, 40, "t1_fill");
    chk("t1_pulses", 32'(pulse_cyc.size()), 32'd3);
    chk("t1_gap1",   32'(pulse_cyc[1] - pulse_cyc[0]), 32'd5);
    chk("t1_gap2",   32'(pulse_cyc[2] - pulse_cyc[1]), 32'd5);
    chk("t1_spawn",  32'(q_if.spawn_block_o), 32'(exp_q[0]));
    chk("t1_prev",   32'(q_if.preview_block_o), 32'(exp_q[1]));
    chk("t1_prev_v", 32'(q_if.preview_valid_o), 32'd1);
    tick(10);
    chk("t1_quiet_pulses", 32'(pulse_cyc.size()), 32'd3);
    chk("t1_quiet_en",     32'(gen_en), 32'd0);

    // 3: one pop from full, refill starts two cycles after the pop edge
    gen_q.push_back(mk(4, 7));
    pop_one("t3_pop_head");
    chk("t3_count", 32'(q_if.count_o), 32'd2);
    chk("t3_head",  32'(q_if.spawn_block_o), 32'(exp_q[0]));
    chk("t3_en_lo", 32'(gen_en), 32'd0);
    tick(1);
    chk("t3_en_hi", 32'(gen_en), 32'd1);
    exp_q.push_back(mk(4, 7));
    wait_count(3, 20, "t3_refill");
    chk("t3_tail", 32'(q_if.preview_block_o), 32'(exp_q[1]));

    // 2: repeat rejection with bounded rerolls
    gen_q = '{mk(1, 4), mk(2, 4), mk(3, 4), mk(4, 4), mk(5, 2)};
    exp_q = '{mk(1, 4), mk(4, 4), mk(5, 2)};
    pulse_cyc.delete();
    do_flush();
    chk("t2_flush_count", 32'(q_if.count_o), 32'd0);
    wait_count(3, 80, "t2_fill");
    chk("t2_pulses", 32'(pulse_cyc.size()), 32'd5);
    chk("t2_prev",   32'(q_if.preview_block_o), 32'(exp_q[1]));
    pop_one("t2_pop_head");
    chk("t2_head2", 32'(q_if.spawn_block_o), 32'(exp_q[0]));
    chk("t2_prev2", 32'(q_if.preview_block_o), 32'(exp_q[1]));

    // 4: pop on the same edge as a push with one entry queued
    gen_q.delete();
    gen_q = '{mk(1, 2), mk(2, 3)};
    exp_q = '{mk(1, 2), mk(2, 3)};
    do_flush();
    wait_count(1, 30, "t4_first");
    wait_gen(10, "t4_step");
    tick(3);
    chk("t4_pre_count", 32'(q_if.count_o), 32'd1);
    pop_one("t4_pop_head");
    chk("t4_count",  32'(q_if.count_o), 32'd1);
    chk("t4_head",   32'(q_if.spawn_block_o), 32'(exp_q[0]));
    chk("t4_prev_v", 32'(q_if.preview_valid_o), 32'd0);

    // 5: flush during WAIT with two entries, same color accepted afterwards
    gen_q.delete();
    gen_q = '{mk(1, 5), mk(2, 6), mk(3, 7), mk(5, 6)};
    exp_q = '{mk(1, 5), mk(2, 6)};
    do_flush();
    wait_count(2, 40, "t5_two");
    chk("t5_spawn", 32'(q_if.spawn_block_o), 32'(exp_q[0]));
    chk("t5_prev",  32'(q_if.preview_block_o), 32'(exp_q[1]));
    wait_gen(10, "t5_step");
    tick(1);
    flush            = 1'b1;
    q_if.spawn_req_i = 1'b1;
    tick(1);
    flush            = 1'b0;
    q_if.spawn_req_i = 1'b0;
    chk("t5_count",  32'(q_if.count_o), 32'd0);
    chk("t5_spawn_v", 32'(q_if.spawn_valid_o), 32'd0);
    chk("t5_prev_v", 32'(q_if.preview_valid_o), 32'd0);
    exp_q = '{mk(5, 6)};
    wait_count(1, 30, "t5_refill");
    chk("t5_same_color", 32'(q_if.spawn_block_o), 32'(exp_q[0]));

    // 6: async reset during WAIT, no stale sample afterwards
    wait_gen(40, "t6_step");
    tick(1);
    rst_n = 1'b0;
    #1;
    chk("t6_en",      32'(gen_en), 32'd0);
    chk("t6_count",   32'(q_if.count_o), 32'd0);
    chk("t6_spawn_v", 32'(q_if.spawn_valid_o), 32'd0);
    chk("t6_prev_v",  32'(q_if.preview_valid_o), 32'd0);
    chk("t6_spawn_b", 32'(q_if.spawn_block_o), 32'd0);
    chk("t6_prev_b",  32'(q_if.preview_block_o), 32'd0);
    gen_q.delete();
    gen_q = '{mk(6, 3)};
    exp_q = '{mk(6, 3)};
    tick(2);
    rst_n = 1'b1;
    wait_gen(10, "t6_first_step");
    tick(3);
    chk("t6_not_yet", 32'(q_if.count_o), 32'd0);
    tick(1);
    chk("t6_pushed", 32'(q_if.count_o), 32'd1);
    chk("t6_head",   32'(q_if.spawn_block_o), 32'(exp_q[0]));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
